// File: rtl/mips_pkg.sv
// Shared MIPS encoding definitions: opcodes, functs, op-select codes and the
// structured request type consumed by the encoder.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    typedef enum logic [2:0] {
        SEL_ADDU = 3'd0,
        SEL_SUBU = 3'd1,
        SEL_ORI  = 3'd2,
        SEL_LW   = 3'd3,
        SEL_SW   = 3'd4,
        SEL_BEQ  = 3'd5,
        SEL_LUI  = 3'd6,
        SEL_J    = 3'd7
    } op_sel_t;

    typedef struct packed {
        op_sel_t     op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [25:0] target;
    } instr_req_t;

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Request handshake plus instruction-memory write bus of the encoder/loader.
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_encoder_loader_encode.sv
// Purely combinational request-to-MIPS-word encoder; unused fields are
// dropped so they can never leak into the word.
module instr_encode
    import mips_pkg::*;
(
    input  instr_req_t  req,
    output logic [31:0] word
);

    always_comb begin
        word = '0;
        case (req.op)
            SEL_ADDU: word = {OP_RTYPE, req.rs, req.rt, req.rd, 5'd0, FN_ADDU};
            SEL_SUBU: word = {OP_RTYPE, req.rs, req.rt, req.rd, 5'd0, FN_SUBU};
            SEL_ORI:  word = {OP_ORI,   req.rs, req.rt, req.imm};
            SEL_LW:   word = {OP_LW,    req.rs, req.rt, req.imm};
            SEL_SW:   word = {OP_SW,    req.rs, req.rt, req.imm};
            SEL_BEQ:  word = {OP_BEQ,   req.rs, req.rt, req.imm};
            // LUI has no source register: rs slot is architecturally zero
            SEL_LUI:  word = {OP_LUI,   5'd0,   req.rt, req.imm};
            SEL_J:    word = {OP_J,     req.target};
            default:  word = '0;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes instruction requests and streams them into instruction memory at
// consecutive word addresses, tracking count, full and an XOR checksum.
module instr_encoder_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024,
    parameter int BASE   = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    instr_encoder_loader_if.slave  bus,
    output logic [ADDR_W:0]        count,
    output logic                   full,
    output logic [31:0]            checksum
);

    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

    instr_req_t        req;
    logic [31:0]       word;
    logic              accept;

    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [31:0]       mem_wdata_reg;
    logic [ADDR_W-1:0] ptr_reg;
    logic [ADDR_W:0]   count_reg;
    logic              full_reg;
    logic [31:0]       checksum_reg;

    assign req = '{
        op:     op_sel_t'(bus.in_op),
        rs:     bus.in_rs,
        rt:     bus.in_rt,
        rd:     bus.in_rd,
        imm:    bus.in_imm,
        target: bus.in_target
    };

    instr_encode u_encode (
        .req  (req),
        .word (word)
    );

    // Ready is the only combinational output; held low while in reset too
    assign bus.in_ready = rst_n && !full_reg && !clr;
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= BASE_ADDR;
            mem_wdata_reg <= '0;
            ptr_reg       <= BASE_ADDR;
            count_reg     <= '0;
            full_reg      <= 1'b0;
            checksum_reg  <= '0;
        end else begin
            mem_we_reg <= accept;
            if (accept) begin
                mem_addr_reg  <= ptr_reg;
                mem_wdata_reg <= word;
            end
            // accept already excludes clr, so the in-flight write still lands
            if (clr) begin
                ptr_reg      <= BASE_ADDR;
                count_reg    <= '0;
                full_reg     <= 1'b0;
                checksum_reg <= '0;
            end else if (accept) begin
                ptr_reg      <= ptr_reg + PTR_ONE;
                count_reg    <= count_reg + CNT_ONE;
                full_reg     <= (count_reg + CNT_ONE) == DEPTH_CNT;
                checksum_reg <= checksum_reg ^ word;
            end
        end
    end

    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign count         = count_reg;
    assign full          = full_reg;
    assign checksum      = checksum_reg;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench: vector table, hand sequences for clr/reset/full, and
// random traffic against a behavioural model of the loader.
module tb_instr_encoder_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic clr;
    logic s_clr;

    instr_encoder_loader_if #(.ADDR_W(10)) m_if ();
    instr_encoder_loader_if #(.ADDR_W(10)) w_if ();
    instr_encoder_loader_if #(.ADDR_W(10)) s_if ();

    logic [10:0] m_count, w_count, s_count;
    logic        m_full, w_full, s_full;
    logic [31:0] m_chk, w_chk, s_chk;

    // Wrap instance sees exactly the main stream, only its base differs
    assign w_if.in_valid  = m_if.in_valid;
    assign w_if.in_op     = m_if.in_op;
    assign w_if.in_rs     = m_if.in_rs;
    assign w_if.in_rt     = m_if.in_rt;
    assign w_if.in_rd     = m_if.in_rd;
    assign w_if.in_imm    = m_if.in_imm;
    assign w_if.in_target = m_if.in_target;

    instr_encoder_loader #(.ADDR_W(10), .DEPTH(1024), .BASE(0)) u_main (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(m_if),
        .count(m_count), .full(m_full), .checksum(m_chk)
    );
    instr_encoder_loader #(.ADDR_W(10), .DEPTH(1024), .BASE(1020)) u_wrap (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(w_if),
        .count(w_count), .full(w_full), .checksum(w_chk)
    );
    instr_encoder_loader #(.ADDR_W(10), .DEPTH(4), .BASE(0)) u_small (
        .clk(clk), .rst_n(rst_n), .clr(s_clr), .bus(s_if),
        .count(s_count), .full(s_full), .checksum(s_chk)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Standard MIPS field layout computed arithmetically from the ISA
    function automatic logic [31:0] ref_enc(input logic [2:0] op, input logic [4:0] rs,
                                            input logic [4:0] rt, input logic [4:0] rd,
                                            input logic [15:0] imm, input logic [25:0] tgt);
        logic [31:0] r_s, r_t, r_d, im;
        r_s = 32'(rs) << 21;
        r_t = 32'(rt) << 16;
        r_d = 32'(rd) << 11;
        im  = 32'(imm);
        case (op)
            3'd0: return r_s | r_t | r_d | 32'd33;
            3'd1: return r_s | r_t | r_d | 32'd35;
            3'd2: return (32'd13 << 26) | r_s | r_t | im;
            3'd3: return (32'd35 << 26) | r_s | r_t | im;
            3'd4: return (32'd43 << 26) | r_s | r_t | im;
            3'd5: return (32'd4 << 26) | r_s | r_t | im;
            3'd6: return (32'd15 << 26) | r_t | im;
            default: return (32'd2 << 26) | 32'(tgt);
        endcase
    endfunction

    // Behavioural model of the main and wrap instances
    int          e_cnt;
    logic        e_we;
    logic [9:0]  e_addr, e_waddr;
    logic [31:0] e_wdata, e_chk;

    task automatic drive(input bit v, input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
        m_if.in_valid  = v;
        m_if.in_op     = op;
        m_if.in_rs     = rs;
        m_if.in_rt     = rt;
        m_if.in_rd     = rd;
        m_if.in_imm    = imm;
        m_if.in_target = tgt;
    endtask

    task automatic step(input string tag);
        bit          acc;
        logic [31:0] word;
        #1;
        check({tag, " in_ready"}, 32'(m_if.in_ready), 32'(rst_n && e_cnt != 1024 && !clr));
        acc  = rst_n && m_if.in_valid && e_cnt != 1024 && !clr;
        word = ref_enc(m_if.in_op, m_if.in_rs, m_if.in_rt, m_if.in_rd, m_if.in_imm, m_if.in_target);
        @(posedge clk);
        if (!rst_n) begin
            e_we = 0; e_addr = 10'd0; e_waddr = 10'd1020; e_wdata = '0; e_cnt = 0; e_chk = '0;
        end else begin
            e_we = acc;
            if (acc) begin
                e_addr  = 10'(e_cnt);
                e_waddr = 10'((1020 + e_cnt) % 1024);
                e_wdata = word;
                e_cnt++;
                e_chk   = e_chk ^ word;
            end
            if (clr) begin
                e_cnt = 0;
                e_chk = '0;
            end
        end
        #1;
        check({tag, " mem_we"},    32'(m_if.mem_we),   32'(e_we));
        check({tag, " mem_addr"},  32'(m_if.mem_addr), 32'(e_addr));
        check({tag, " mem_wdata"}, m_if.mem_wdata,     e_wdata);
        check({tag, " count"},     32'(m_count),       32'(e_cnt));
        check({tag, " full"},      32'(m_full),        32'(e_cnt == 1024));
        check({tag, " checksum"},  m_chk,              e_chk);
        check({tag, " wrap we"},   32'(w_if.mem_we),   32'(e_we));
        check({tag, " wrap addr"}, 32'(w_if.mem_addr), 32'(e_waddr));
        check({tag, " wrap data"}, w_if.mem_wdata,     e_wdata);
        check({tag, " wrap cnt"},  32'(w_count),       32'(e_cnt));
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [9];

    initial begin
        logic [31:0] x4;
        int          k, pulses;

        tbl[0] = '{3'd0, 5'd1,  5'd2,  5'd3,  16'h0000, 26'h0,       32'h00221821};
        tbl[1] = '{3'd2, 5'd0,  5'd1,  5'd31, 16'h1234, 26'h3FFFFFF, 32'h34011234};
        tbl[2] = '{3'd3, 5'd2,  5'd3,  5'd0,  16'h0004, 26'h0,       32'h8C430004};
        tbl[3] = '{3'd5, 5'd1,  5'd2,  5'd0,  16'hFFFF, 26'h0,       32'h1022FFFF};
        tbl[4] = '{3'd6, 5'd5,  5'd4,  5'd0,  16'hABCD, 26'h0,       32'h3C04ABCD};
        tbl[5] = '{3'd7, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h0000003, 32'h08000003};
        tbl[6] = '{3'd1, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 32'h03FFF823};
        tbl[7] = '{3'd6, 5'd31, 5'd0,  5'd31, 16'h0000, 26'h3FFFFFF, 32'h3C000000};
        tbl[8] = '{3'd4, 5'd2,  5'd3,  5'd31, 16'h0008, 26'h3FFFFFF, 32'hAC430008};

        rst_n = 1'b0; clr = 1'b0; s_clr = 1'b0;
        e_cnt = 0; e_we = 0; e_addr = '0; e_waddr = 10'd1020; e_wdata = '0; e_chk = '0;
        drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        s_if.in_valid = 1'b0; s_if.in_op = '0; s_if.in_rs = '0; s_if.in_rt = '0;
        s_if.in_rd = '0; s_if.in_imm = '0; s_if.in_target = '0;

        step("reset");
        step("reset");
        rst_n = 1'b1;
        step("idle");

        // Vector table back to back: continuous writes at 0.. and wrap 1020..1023,0..
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].imm, tbl[i].tgt);
            step("tbl");
            check($sformatf("tbl%0d word", i), m_if.mem_wdata, tbl[i].exp);
            check($sformatf("tbl%0d addr", i), 32'(m_if.mem_addr), 32'(i));
            check($sformatf("tbl%0d we", i), 32'(m_if.mem_we), 32'd1);
            if (i == 4)
                check("wrap fifth addr", 32'(w_if.mem_addr), 32'd0);
        end
        drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        step("hold");
        check("hold addr", 32'(m_if.mem_addr), 32'd8);

        // clr with a concurrent request at count 2
        clr = 1'b1; step("clr0"); clr = 1'b0;
        drive(1'b1, tbl[0].op, tbl[0].rs, tbl[0].rt, tbl[0].rd, tbl[0].imm, tbl[0].tgt);
        step("pre"); step("pre");
        check("pre count", 32'(m_count), 32'd2);
        clr = 1'b1;
        drive(1'b1, tbl[2].op, tbl[2].rs, tbl[2].rt, tbl[2].rd, tbl[2].imm, tbl[2].tgt);
        step("clr");
        check("clr count", 32'(m_count), 32'd0);
        check("clr chk", m_chk, 32'd0);
        clr = 1'b0;
        step("post clr");
        check("post clr addr", 32'(m_if.mem_addr), 32'd0);
        check("post clr word", m_if.mem_wdata, tbl[2].exp);

        // Reset during streaming drops the pending write
        step("stream");
        rst_n = 1'b0;
        step("mid reset");
        check("mid reset we", 32'(m_if.mem_we), 32'd0);
        check("mid reset count", 32'(m_count), 32'd0);
        rst_n = 1'b1;
        drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        step("after reset");

        // DEPTH=4 instance: request held for 6 cycles
        k = 0; pulses = 0; x4 = '0;
        for (int c = 0; c < 6; c++) begin
            s_if.in_valid = 1'b1;
            s_if.in_op = tbl[k].op; s_if.in_rs = tbl[k].rs; s_if.in_rt = tbl[k].rt;
            s_if.in_rd = tbl[k].rd; s_if.in_imm = tbl[k].imm; s_if.in_target = tbl[k].tgt;
            #1;
            check($sformatf("small ready c%0d", c), 32'(s_if.in_ready), 32'(k < 4));
            @(posedge clk);
            if (k < 4) begin
                x4 = x4 ^ tbl[k].exp;
                k++;
            end
            #1;
            if (s_if.mem_we) pulses++;
        end
        check("small pulses", 32'(pulses), 32'd4);
        check("small count", 32'(s_count), 32'd4);
        check("small full", 32'(s_full), 32'd1);
        check("small ready", 32'(s_if.in_ready), 32'd0);
        check("small chk", s_chk, x4);
        check("small last addr", 32'(s_if.mem_addr), 32'd3);
        check("small last word", s_if.mem_wdata, tbl[3].exp);
        s_if.in_valid = 1'b0;

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            clr   = ($urandom_range(0, 29) == 0);
            drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 5'($urandom),
                  5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom));
            step("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Encoder counterpart to the control decoder: turns structured instruction requests (op select plus fields) into 32-bit MIPS words.
- Writes each encoded word into instruction memory at consecutive word addresses.
- Used by the self-test/boot path to build programs for the single-cycle CPU.
- Supported set: ADDU, SUBU, ORI, LW, SW, BEQ, LUI, J.

Parameters:
- ADDR_W, 10, width of the instruction-memory word address.
- DEPTH, 1024, number of words loadable before full; must be ≤ 2^ADDR_W.
- BASE, 0, word address of the first write.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- clr  input  1  restart load: zeroes count, pointer and checksum.
- in_valid  input  1  request present.
- in_ready  output  1  request accepted when in_valid && in_ready.
- in_op  input  3  op select: 0 ADDU, 1 SUBU, 2 ORI, 3 LW, 4 SW, 5 BEQ, 6 LUI, 7 J.
- in_rs  input  5  source register.
- in_rt  input  5  target register.
- in_rd  input  5  destination register (R-type only).
- in_imm  input  16  immediate / branch offset.
- in_target  input  26  jump target (J only).
- mem_we  output  1  instruction-memory write strobe.
- mem_addr  output  ADDR_W  word address of the write.
- mem_wdata  output  32  encoded instruction.
- count  output  ADDR_W+1  number of words accepted since reset/clr.
- full  output  1  count == DEPTH.
- checksum  output  32  XOR of all words written.

Behaviour:
- Reset (rst_n low at a clk edge): in_ready=0 during reset, then 1. mem_we=0, mem_addr=BASE, mem_wdata=0, count=0, full=0, checksum=0. Any pending write is dropped.
- Encoding is standard MIPS:
  - ADDU: {000000, rs, rt, rd, 00000, 100001}.
  - SUBU: funct 100011.
  - ORI: {001101, rs, rt, imm}.
  - LW: opcode 100011.
  - SW: opcode 101011.
  - BEQ: opcode 000100.
  - LUI: {001111, 00000, rt, imm}; rs is forced to 0.
  - J: {000010, target}.
  - Fields unused by an op are ignored and never leak into the word.
- in_ready = !full && !clr.
- Pipeline, one stage:
  - Accept at edge N registers the encoded word into mem_wdata and the write pointer into mem_addr.
  - mem_we is high during cycle N+1.
  - count increments at edge N.
  - checksum updates at edge N with the new word (checksum ^= word).
  - Latency: 1 cycle, accept to write.
- Throughput: one word per cycle. Back-to-back accepts give continuous mem_we with mem_addr incrementing by 1.
- No accept in a cycle: mem_we=0 the next cycle; mem_addr/mem_wdata hold their last values.
- Write pointer = BASE + accepted count. Arithmetic is modulo 2^ADDR_W, so it wraps if BASE+DEPTH exceeds the address space.
- Full: asserted at the edge where count reaches DEPTH.
  - in_ready drops in the same cycle.
  - The last word is still written in the following cycle.
  - A request while full is not accepted; the requester must hold it.
- clr (synchronous, active-high):
  - Same cycle: in_ready=0, so a concurrent request is not accepted.
  - Next edge: count=0, pointer=BASE, checksum=0, full=0.
  - A write already in flight (mem_we that cycle) completes.
- rst_n has priority over clr.
- Outputs are all registered except in_ready, which is combinational from full and clr.

Decomposition:
- Shared package mips_pkg:
  - Opcode constants: OP_RTYPE, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_LUI, OP_J.
  - Funct constants: FN_ADDU, FN_SUBU.
  - The 3-bit op-select encoding, so the decoder and encoder share one definition.
- Sub-module instr_encode: purely combinational in_op/fields → 32-bit word. The top holds the handshake, pointer, counter, checksum and output registers.

Test Plan:
- Reset then ADDU rs=1 rt=2 rd=3 → one cycle later mem_we=1, mem_addr=0, mem_wdata=0x00221821, count=1.
- Back-to-back over 5 cycles:
  - ORI rs=0 rt=1 imm=0x1234 → 0x34011234.
  - LW rs=2 rt=3 imm=4 → 0x8C430004.
  - BEQ rs=1 rt=2 imm=0xFFFF → 0x1022FFFF.
  - LUI rs=5 rt=4 imm=0xABCD → 0x3C04ABCD.
  - J target=3 → 0x08000003.
  - Expect addresses 0..4 consecutive and mem_we continuously high.
- Field masking: SUBU with in_imm=0xFFFF, in_target all-ones, rs=rt=rd=31 → 0x03FFF823. LUI ignores rs.
- DEPTH=4: hold in_valid for 6 cycles:
  - 4 accepts, then full=1 and in_ready=0.
  - Exactly 4 mem_we pulses; the held request stays pending.
  - checksum equals the XOR of the 4 words.
- clr asserted with in_valid high while count=2 → request not accepted; next cycle count=0, checksum=0, next write lands at BASE.
- rst_n low during streaming → the pending write is dropped and all outputs take reset values. BASE=1020 with ADDR_W=10 → fifth write lands at address 0 (wrap).
